// File: rtl/regfile_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq_ctrl
// Description : Instruction-ROM micro-sequencer mastering a 4x8 register file
//               write port and steering its read selects and the ALU op.
//               Optional macro SINGLE_STEP_EN adds a step input gating FETCH.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq_ctrl #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  output logic [7:0]      rf_d,
  output logic            rf_we,
  output logic [1:0]      rf_add,
  output logic [1:0]      rf_cha,
  output logic [1:0]      rf_chb,
  input  logic [7:0]      rf_da,
  input  logic [7:0]      alu_y,
  output logic            alu_sub,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_IMM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] C_OP_LDI  = 2'b00;
  localparam logic [1:0] C_OP_ADD  = 2'b01;
  localparam logic [1:0] C_OP_SUB  = 2'b10;
  localparam logic [1:0] C_OP_SPC  = 2'b11;
  localparam logic [1:0] C_SUB_JNZ = 2'b00;
  localparam logic [1:0] C_SUB_JMP = 2'b01;
  localparam logic [1:0] C_SUB_NOP = 2'b10;
  localparam logic [PC_W-1:0] C_RST_PC = RESET_PC[PC_W-1:0];

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        imm_q, imm_d;

  logic [1:0]        w_op, w_rd, w_ra, w_rb;
  logic              w_is_arith, w_is_jnz, w_is_jmp, w_step_ok;
  logic [PC_W-1:0]   w_pc_inc, w_tgt;

  assign w_op       = ir_q[7:6];
  assign w_rd       = ir_q[5:4];
  assign w_ra       = ir_q[3:2];
  assign w_rb       = ir_q[1:0];
  assign w_is_arith = (w_op == C_OP_ADD) || (w_op == C_OP_SUB);
  assign w_is_jnz   = (w_op == C_OP_SPC) && (w_ra == C_SUB_JNZ);
  assign w_is_jmp   = (w_op == C_OP_SPC) && (w_ra == C_SUB_JMP);
  assign w_pc_inc   = pc_q + PC_W'(1);
  assign w_tgt      = rom_data[PC_W-1:0];

`ifdef SINGLE_STEP_EN
  assign w_step_ok = step;
`else
  assign w_step_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= C_RST_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (w_step_ok) begin
          ir_d    = rom_data;
          pc_d    = w_pc_inc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_op)
          C_OP_LDI: state_d = S_IMM;
          C_OP_ADD,
          C_OP_SUB: state_d = S_EXEC;
          default: begin
            if (w_is_jnz || w_is_jmp) state_d = S_IMM;
            else if (w_ra == C_SUB_NOP) state_d = S_FETCH;
            else state_d = S_HALT;
          end
        endcase
      end
      S_IMM: begin
        // The second byte is consumed here regardless; jumps override the PC.
        pc_d    = w_pc_inc;
        state_d = S_FETCH;
        if (w_op == C_OP_LDI) begin
          imm_d   = rom_data;
          state_d = S_EXEC;
        end else if (w_is_jmp || (w_is_jnz && (rf_da != 8'h00))) begin
          pc_d = w_tgt;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = C_RST_PC;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rom_addr = pc_q;
    rf_we    = 1'b0;
    rf_add   = 2'b00;
    rf_d     = 8'h00;
    rf_cha   = 2'b00;
    rf_chb   = 2'b00;
    alu_sub  = 1'b0;
    busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
               (state_q == S_IMM)   || (state_q == S_EXEC);
    halted   = (state_q == S_HALT);
    if (w_is_arith) begin
      rf_cha  = w_ra;
      rf_chb  = w_rb;
      alu_sub = (w_op == C_OP_SUB);
    end else if ((state_q == S_IMM) && w_is_jnz) begin
      rf_cha = w_rd;
    end
    // Gating with rst keeps a reset cycle from ever committing a write.
    if (state_q == S_EXEC) begin
      rf_we  = !rst;
      rf_add = w_rd;
      rf_d   = (w_op == C_OP_LDI) ? imm_q : alu_y;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_seq_ctrl
// Description : Directed bench with ROM, register file and ALU models for two
//               sequencer instances (PC_W=8 from 0, PC_W=4 from 14).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: PC_W=8, RESET_PC=0
  logic       start_a = 1'b0;
  logic       step_a  = 1'b1;
  logic [7:0] rom_addr_a, rom_data_a, rf_d_a, rf_da_a, alu_y_a;
  logic       rf_we_a, alu_sub_a, busy_a, halted_a;
  logic [1:0] rf_add_a, rf_cha_a, rf_chb_a;
  logic [7:0] rom_a [256];
  logic [7:0] regs_a [4];

  // Instance B: PC_W=4, RESET_PC=14
  logic       start_b = 1'b0;
  logic       step_b  = 1'b1;
  logic [3:0] rom_addr_b;
  logic [7:0] rom_data_b, rf_d_b, rf_da_b, alu_y_b;
  logic       rf_we_b, alu_sub_b, busy_b, halted_b;
  logic [1:0] rf_add_b, rf_cha_b, rf_chb_b;
  logic [7:0] rom_b [16];
  logic [7:0] regs_b [4];

  assign rom_data_a = rom_a[rom_addr_a];
  assign rf_da_a    = regs_a[rf_cha_a];
  assign alu_y_a    = alu_sub_a ? (regs_a[rf_cha_a] - regs_a[rf_chb_a])
                                : (regs_a[rf_cha_a] + regs_a[rf_chb_a]);
  assign rom_data_b = rom_b[rom_addr_b];
  assign rf_da_b    = regs_b[rf_cha_b];
  assign alu_y_b    = alu_sub_b ? (regs_b[rf_cha_b] - regs_b[rf_chb_b])
                                : (regs_b[rf_cha_b] + regs_b[rf_chb_b]);

  int         we_cnt_a  = 0;
  int         sub_cnt_a = 0;
  logic [7:0] sub_vals [8];

  always @(posedge clk) begin
    if (rf_we_a) begin
      regs_a[rf_add_a] <= rf_d_a;
      we_cnt_a <= we_cnt_a + 1;
      if (alu_sub_a && rf_add_a == 2'd0 && sub_cnt_a < 8) begin
        sub_vals[sub_cnt_a] <= rf_d_a;
        sub_cnt_a <= sub_cnt_a + 1;
      end
    end
    if (rf_we_b) regs_b[rf_add_b] <= rf_d_b;
  end

  regfile_seq_ctrl #(.PC_W(8), .RESET_PC(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
`ifdef SINGLE_STEP_EN
    .step(step_a),
`endif
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .rf_d(rf_d_a), .rf_we(rf_we_a), .rf_add(rf_add_a),
    .rf_cha(rf_cha_a), .rf_chb(rf_chb_a), .rf_da(rf_da_a),
    .alu_y(alu_y_a), .alu_sub(alu_sub_a), .busy(busy_a), .halted(halted_a)
  );

  regfile_seq_ctrl #(.PC_W(4), .RESET_PC(14)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef SINGLE_STEP_EN
    .step(step_b),
`endif
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .rf_d(rf_d_b), .rf_we(rf_we_b), .rf_add(rf_add_b),
    .rf_cha(rf_cha_b), .rf_chb(rf_chb_b), .rf_da(rf_da_b),
    .alu_y(alu_y_b), .alu_sub(alu_sub_b), .busy(busy_b), .halted(halted_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) rom_a[i] = 8'hCC;
    for (int i = 0; i < 16; i++) rom_b[i] = 8'hCC;
    for (int i = 0; i < 4; i++) begin
      regs_a[i] = 8'h00;
      regs_b[i] = 8'h00;
    end
    rom_a[0] = 8'h00; rom_a[1] = 8'h05; rom_a[2] = 8'h50; rom_a[3] = 8'hCC;
    rom_b[14] = 8'hC4; rom_b[15] = 8'h02; rom_b[2] = 8'hCC;

    tick(2);
    rst = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_halted", halted_a, 0);
    check("rst_addr_a", rom_addr_a, 8'h00);
    check("rst_addr_b", rom_addr_b, 14);
    check("rst_we", rf_we_a, 0);
    check("rst_d", rf_d_a, 0);
    tick(2);
    check("idle_hold", busy_a, 0);

    // LDI r0,5 ; ADD r1=r0+r0 ; HLT, with start held through busy cycles
    start_a = 1'b1;
    tick(1);
    check("s1_fetch_busy", busy_a, 1);
    check("s1_fetch_addr", rom_addr_a, 0);
    tick(2);
    check("s1_imm_addr", rom_addr_a, 1);
    start_a = 1'b0;
    tick(1);
    check("s1_ldi_we", rf_we_a, 1);
    check("s1_ldi_add", rf_add_a, 0);
    check("s1_ldi_d", rf_d_a, 8'h05);
    tick(1);
    check("s1_fetch2_addr", rom_addr_a, 2);
    check("s1_fetch2_we", rf_we_a, 0);
    tick(1);
    check("s1_add_cha", rf_cha_a, 0);
    check("s1_add_chb", rf_chb_a, 0);
    check("s1_add_sub", alu_sub_a, 0);
    tick(1);
    check("s1_add_we", rf_we_a, 1);
    check("s1_add_add", rf_add_a, 1);
    check("s1_add_d", rf_d_a, 8'h0A);
    tick(3);
    check("s1_halted", halted_a, 1);
    check("s1_halt_busy", busy_a, 0);
    check("s1_halt_addr", rom_addr_a, 4);
    check("s1_r1", regs_a[1], 8'h0A);
    tick(2);
    check("s1_halt_stays", halted_a, 1);

    // Restart from HALT replays the program from address 0
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    check("rs_addr", rom_addr_a, 0);
    check("rs_halted", halted_a, 0);
    tick(3);
    check("rs_ldi_d", rf_d_a, 8'h05);
    check("rs_ldi_we", rf_we_a, 1);
    tick(3);
    check("rs_add_d", rf_d_a, 8'h0A);
    check("rs_add_add", rf_add_a, 1);
    tick(3);
    check("rs_halted2", halted_a, 1);

    // Reset asserted during LDI EXEC aborts the write
    rom_a[1] = 8'h77;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(3);
    check("ra_pre_d", rf_d_a, 8'h77);
    rst = 1'b1;
    #1;
    check("ra_we_gated", rf_we_a, 0);
    tick(1);
    rst = 1'b0;
    check("ra_idle", busy_a, 0);
    check("ra_not_halted", halted_a, 0);
    check("ra_addr", rom_addr_a, 0);
    check("ra_r0", regs_a[0], 8'h05);

    // Countdown loop: LDI r0,3 ; LDI r1,1 ; SUB ; JNZ r0,4 ; HLT
    rom_a[0] = 8'h00; rom_a[1] = 8'h03; rom_a[2] = 8'h10; rom_a[3] = 8'h01;
    rom_a[4] = 8'h81; rom_a[5] = 8'hC0; rom_a[6] = 8'h04; rom_a[7] = 8'hCC;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(9);
    check("cd_sub_cha", rf_cha_a, 0);
    check("cd_sub_chb", rf_chb_a, 1);
    check("cd_sub_alu", alu_sub_a, 1);
    tick(1);
    check("cd_sub_d", rf_d_a, 8'h02);
    check("cd_sub_add", rf_add_a, 0);
    cyc = 10;
    while (!halted_a && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("cd_cycles", cyc, 28);
    check("cd_sub_cnt", sub_cnt_a, 3);
    check("cd_sub_v0", sub_vals[0], 8'h02);
    check("cd_sub_v1", sub_vals[1], 8'h01);
    check("cd_sub_v2", sub_vals[2], 8'h00);
    check("cd_r0", regs_a[0], 8'h00);
    check("cd_r1", regs_a[1], 8'h01);
    check("cd_addr", rom_addr_a, 8);

    // PC_W=4: JMP at 14, target byte at 15, lands on 2
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    check("jw_fetch_addr", rom_addr_b, 14);
    tick(1);
    check("jw_dec_addr", rom_addr_b, 15);
    tick(1);
    check("jw_imm_addr", rom_addr_b, 15);
    tick(1);
    check("jw_tgt_addr", rom_addr_b, 2);
    tick(2);
    check("jw_halted", halted_b, 1);
    check("jw_halt_addr", rom_addr_b, 3);

    // NOP at 14, LDI at 15 whose immediate sits at 0 after the wrap
    rom_b[14] = 8'hC8; rom_b[15] = 8'h00; rom_b[0] = 8'h3C; rom_b[1] = 8'hCC;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    check("wr_addr14", rom_addr_b, 14);
    tick(2);
    check("wr_nop_lat", rom_addr_b, 15);
    tick(2);
    check("wr_imm_addr", rom_addr_b, 0);
    tick(1);
    check("wr_we", rf_we_b, 1);
    check("wr_d", rf_d_b, 8'h3C);
    tick(3);
    check("wr_halted", halted_b, 1);
    check("wr_addr", rom_addr_b, 2);
    check("wr_r0", regs_b[0], 8'h3C);

`ifdef SINGLE_STEP_EN
    begin
      int base;
      rom_a[0] = 8'h00; rom_a[1] = 8'h05; rom_a[2] = 8'hCC;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      step_a = 1'b0;
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      base = we_cnt_a;
      tick(10);
      check("ss_no_write", we_cnt_a - base, 0);
      check("ss_stall_addr", rom_addr_a, 0);
      step_a = 1'b1;
      tick(1);
      step_a = 1'b0;
      tick(10);
      check("ss_one_write", we_cnt_a - base, 1);
      check("ss_r0", regs_a[0], 8'h05);
      check("ss_next_addr", rom_addr_a, 2);
      check("ss_busy", busy_a, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
